// File: rtl/out_fm_tile_ctrl.sv
// out_fm_tile_ctrl: tile sequencer for the Y output_fm banks (load, compute, store, clean).
// Macro OUT_FM_PRELOAD_EN builds the partial-sum LOAD/LDRAIN path; otherwise start goes straight to COMPUTE.
module out_fm_tile_ctrl #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int Tn = 16,
  parameter int Tr = 64,
  parameter int Tc = 16,
  parameter int Y  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  input  logic [DW-1:0]   ld_data_i,
  input  logic            ld_valid_i,
  output logic            ld_ready_o,
  output logic [DW-1:0]   st_data_o,
  output logic            st_valid_o,
  input  logic            st_ready_i,
  output logic            conv_start_o,
  input  logic            conv_done_i,
  output logic            computing_on_going_o,
  output logic            conv_tile_clean_o,
  output logic [DW-1:0]   bank_wr_data_o,
  output logic [Y-1:0]    bank_wr_ena_o,
  output logic [Y-1:0]    bank_rd_ena_o,
  input  logic [Y*DW-1:0] bank_rd_data_i
);
  localparam int TOTAL = Tn * Tr * Tc;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int BW    = (Y > 1) ? $clog2(Y) : 1;

  if (AW < $clog2(TOTAL / Y)) begin : g_aw_check
    $error("out_fm_tile_ctrl: AW too narrow for the bank depth");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LDRAIN, S_COMPUTE, S_STORE, S_CLEAN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bank_q, bank_d;
  logic            in_comp_q;
  logic            infl_q;
  logic [BW-1:0]   infl_bank_q;
  logic [DW-1:0]   fifo_q [2];
  logic            wptr_q, rptr_q;
  logic [1:0]      cnt_q;

  logic            rd_issue, st_fire, fifo_push, fifo_pop;
  logic [DW-1:0]   land_data;
  logic [Y-1:0]    bank_onehot;

  function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
    return (b == BW'(Y - 1)) ? '0 : b + 1'b1;
  endfunction

  assign bank_onehot = Y'(1) << bank_q;

`ifdef OUT_FM_PRELOAD_EN
  logic ld_fire;
  assign ld_ready_o     = (state_q == S_LOAD);
  assign ld_fire        = ld_ready_o & ld_valid_i;
  assign bank_wr_data_o = ld_ready_o ? ld_data_i : '0;
  assign bank_wr_ena_o  = ld_fire ? bank_onehot : '0;
`else
  logic unused_ld;
  assign unused_ld      = ^{ld_data_i, ld_valid_i};
  assign ld_ready_o     = 1'b0;
  assign bank_wr_data_o = '0;
  assign bank_wr_ena_o  = '0;
`endif

  // A read may only be issued when its returning word is guaranteed a FIFO slot.
  assign rd_issue = (state_q == S_STORE) && (wcnt_q < CW'(TOTAL)) &&
                    ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && !infl_q));
  assign bank_rd_ena_o = rd_issue ? bank_onehot : '0;

  assign land_data  = bank_rd_data_i[infl_bank_q * DW +: DW];
  assign st_valid_o = (cnt_q != 2'd0) || infl_q;
  assign st_data_o  = (cnt_q != 2'd0) ? fifo_q[rptr_q] : (infl_q ? land_data : '0);
  assign st_fire    = st_valid_o & st_ready_i;
  // Returning word bypasses the FIFO when it is empty and the consumer takes it at once.
  assign fifo_push  = infl_q && !((cnt_q == 2'd0) && st_ready_i);
  assign fifo_pop   = st_fire && (cnt_q != 2'd0);

  assign busy_o               = (state_q != S_IDLE);
  assign computing_on_going_o = (state_q == S_COMPUTE);
  assign conv_start_o         = (state_q == S_COMPUTE) && !in_comp_q;
  assign conv_tile_clean_o    = (state_q == S_CLEAN);
  assign done_o               = (state_q == S_CLEAN);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    bank_d  = bank_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef OUT_FM_PRELOAD_EN
          state_d = S_LOAD;
          wcnt_d  = '0;
          scnt_d  = '0;
          bank_d  = '0;
`else
          state_d = S_COMPUTE;
`endif
        end
      end
`ifdef OUT_FM_PRELOAD_EN
      S_LOAD: begin
        if (ld_fire) begin
          wcnt_d = wcnt_q + 1'b1;
          bank_d = bank_inc(bank_q);
          if (wcnt_q == CW'(TOTAL - 1)) state_d = S_LDRAIN;
        end
      end
      S_LDRAIN: state_d = S_COMPUTE;
`endif
      S_COMPUTE: begin
        if (conv_done_i) begin
          state_d = S_STORE;
          wcnt_d  = '0;
          scnt_d  = '0;
          bank_d  = '0;
        end
      end
      S_STORE: begin
        if (rd_issue) begin
          wcnt_d = wcnt_q + 1'b1;
          bank_d = bank_inc(bank_q);
        end
        if (st_fire) begin
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == CW'(TOTAL - 1)) state_d = S_CLEAN;
        end
      end
      S_CLEAN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      scnt_q      <= '0;
      bank_q      <= '0;
      in_comp_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_bank_q <= '0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      scnt_q    <= scnt_d;
      bank_q    <= bank_d;
      in_comp_q <= (state_q == S_COMPUTE);
      infl_q    <= rd_issue;
      if (rd_issue) infl_bank_q <= bank_q;
      if (fifo_push) begin
        fifo_q[wptr_q] <= land_data;
        wptr_q         <= ~wptr_q;
      end
      if (fifo_pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(fifo_push) - 2'(fifo_pop);
    end
  end

endmodule

// File: doc/out_fm_tile_ctrl.md
# out_fm_tile_ctrl

Tile-level sequencer for the Y output_fm banks of one output tile. For each tile it streams partial sums in from external memory, hands the banks to the compute engine, streams results back out, then clears the bank address counters. It sits between the load/store DMA streams and the output_fm_bank array. It owns each bank's `wr_ena`/`rd_ena`, `computing_on_going` and `conv_tile_clean`.

## Interface
- AW, 16, bank address width (must match the banks)
- DW, 32, data width
- Tn, 16, output channels per tile (multiple of Y)
- Tr, 64, tile rows
- Tc, 16, tile cols
- Y, 4, number of output_fm banks
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- start  in  1  tile start pulse; ignored while busy
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse at tile completion
- ld_data  in  DW  load stream data
- ld_valid  in  1  load stream valid
- ld_ready  out  1  load stream ready
- st_data  out  DW  store stream data
- st_valid  out  1  store stream valid
- st_ready  in  1  store stream ready
- conv_start  out  1  one-cycle pulse to the compute engine
- conv_done  in  1  compute engine finished; sampled only in COMPUTE
- computing_on_going  out  1  to all banks; high only in COMPUTE
- conv_tile_clean  out  1  to all banks; one-cycle pulse
- bank_wr_data  out  DW  broadcast to all banks' wr_data
- bank_wr_ena  out  Y  one-hot per-bank wr_ena
- bank_rd_ena  out  Y  one-hot per-bank rd_ena
- bank_rd_data  in  Y*DW  bank b rd_data at [b*DW +: DW]

## Operation
- TOTAL = Tn*Tr*Tc words per tile. Each bank holds TOTAL/Y words.
- Word k maps to bank k mod Y, bank-local address k div Y. The bank's internal counter generates the address.
- States: IDLE, LOAD, LDRAIN, COMPUTE, STORE, CLEAN.
- IDLE -> LOAD on start.
- LOAD:
  - ld_ready=1.
  - On each ld_valid&ld_ready, word k asserts bank_wr_ena[k mod Y] combinationally, with bank_wr_data=ld_data.
  - After word TOTAL-1, go to LDRAIN.
- LDRAIN: one cycle, so the bank's registered write of the last word lands before the port mux switches. Then go to COMPUTE.
- COMPUTE:
  - computing_on_going=1.
  - conv_start pulses on the first COMPUTE cycle.
  - On conv_done, go to STORE.
- STORE:
  - Reads are issued in word order. Read k asserts bank_rd_ena[k mod Y] for one cycle.
  - Bank q is valid one cycle later. It is captured from the bank selected by the in-flight read's bank index into a 2-entry output FIFO that drives st_*.
  - A read is issued only when FIFO occupancy + in-flight reads < 2.
  - After all TOTAL words are accepted on st, go to CLEAN.
- CLEAN: conv_tile_clean=1 for one cycle, then go to IDLE. done pulses in the same cycle.
- Counters:
  - Word counters have width $clog2(TOTAL+1).
  - Bank index counter runs modulo Y and wraps Y-1 -> 0.
  - All counters reset to 0 on entering LOAD and STORE.
- Boundary rules:
  - start while busy: ignored.
  - conv_done outside COMPUTE: ignored.
  - ld_valid outside LOAD: no effect (ld_ready=0).
  - Y=1: bank_wr_ena/bank_rd_ena are constant-1 when active.
  - st_ready held low: reads stall with no data loss.
  - rst mid-operation: return to IDLE, flush FIFO, cancel in-flight read, clear all counters. The banks' own counters are not cleared by this reset path; software issues a full tile to realign.

## Timing
- Reset values: busy, done, ld_ready, st_valid, conv_start, computing_on_going, conv_tile_clean, bank_wr_ena, bank_rd_ena are 0. bank_wr_data and st_data are 0.
- start sampled high at cycle 0: LOAD at cycle 1, with ld_ready=1 at cycle 1.
- Load throughput: 1 word/cycle.
- Last load handshake at cycle t: LDRAIN at t+1; COMPUTE, computing_on_going=1 and conv_start at t+2.
- conv_done at cycle u: STORE at u+1, computing_on_going=0 at u+1, first bank_rd_ena at u+1, first st_valid at u+2.
- Store throughput: 1 word/cycle while st_ready=1.
- Last st handshake at cycle v: CLEAN, conv_tile_clean and done at v+1; IDLE at v+2.

## Configuration
- OUT_FM_PRELOAD_EN defined: full flow, IDLE -> LOAD -> LDRAIN -> COMPUTE.
- Not defined: LOAD and LDRAIN are not built. start goes IDLE -> COMPUTE, so conv_start is at cycle 1. ld_ready is tied to 0 and bank_wr_ena to 0. The compute engine is responsible for initializing the first accumulation.

## Test plan
- Tn=4, Y=4, Tr=Tc=2 (TOTAL=16), macro on; ld_data=0..15 back-to-back -> bank_wr_ena cycles 0001,0010,0100,1000 four times; LDRAIN 1 cycle; conv_start 2 cycles after the last word.
- Same config; conv_done 5 cycles after conv_start; banks return data k -> st_data 0..15 in order; conv_tile_clean and done one cycle after the 16th handshake.
- st_ready toggled 1,0,0,1 repeating -> no lost or duplicated word; never more than 2 buffered + in-flight; bank_rd_ena stalls while full.
- start pulsed during COMPUTE and conv_done pulsed during LOAD -> both ignored; state sequence unchanged.
- rst asserted mid-STORE after word 7 -> all outputs 0 asynchronously; FSM in IDLE; a new start runs a full tile.
- Macro off -> start gives conv_start at cycle 1, ld_ready stays 0, bank_wr_ena never asserts.
